// File: rtl/counter_pkg.sv
// Shared constants for the bounded up/down counter family.
// Gives meaningful names to the direction and saturate/wrap control bits.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage : counter_pkg

// File: rtl/updown_counter_bounded_if.sv
// Control/status bundle of the bounded up/down counter.
// The master drives controls and bounds; the slave (the counter) returns count and flags.
interface updown_counter_bounded_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);

  logic              en;
  logic              up;
  logic [STEP_W-1:0] step;
  logic              sat;
  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  hi;

  logic [WIDTH-1:0]  q;
  logic              at_lo;
  logic              at_hi;
  logic              wrap;
  logic              hit;
  logic              cfg_err;

  modport master (
    output en, up, step, sat, clr, load, load_val, lo, hi,
    input  q, at_lo, at_hi, wrap, hit, cfg_err
  );

  modport slave (
    input  en, up, step, sat, clr, load, load_val, lo, hi,
    output q, at_lo, at_hi, wrap, hit, cfg_err
  );

endinterface : updown_counter_bounded_if

// File: rtl/counter_next_calc.sv
// Combinational next-count step for an in-range q: adds or subtracts step,
// then saturates or wraps at the [lo,hi] bounds and reports which one happened.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  q,
  input  logic [STEP_W-1:0] step,
  input  logic              up,
  input  logic              sat,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  q_nxt,
  output logic              wrap_nxt,
  output logic              hit_nxt
);

  // One extra bit so an overflow past 2^WIDTH-1 or a borrow below zero stays visible.
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           borrow;

  assign step_x = (WIDTH+1)'(step);
  assign sum    = {1'b0, q} + step_x;
  assign diff   = {1'b0, q} - step_x;
  assign borrow = diff[WIDTH];

  // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    hit_nxt  = 1'b0;
    if (step != '0) begin
      if (up == DIR_UP) begin
        if (sum <= {1'b0, hi}) begin
          q_nxt = sum[WIDTH-1:0];
        end else if (sat == MODE_SAT) begin
          q_nxt   = hi;
          hit_nxt = 1'b1;
        end else begin
          q_nxt    = lo;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!borrow && (diff[WIDTH-1:0] >= lo)) begin
          q_nxt = diff[WIDTH-1:0];
        end else if (sat == MODE_SAT) begin
          q_nxt   = lo;
          hit_nxt = 1'b1;
        end else begin
          q_nxt    = hi;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

endmodule : counter_next_calc

// File: rtl/updown_counter_bounded.sv
// Bounded up/down counter: registered count with clear/load/count priority,
// load clamping, out-of-range recovery and single-cycle wrap/hit pulses.
module updown_counter_bounded
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               STEP_W  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                     clk,
  input logic                     rst,
  updown_counter_bounded_if.slave bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_d;
  logic             wrap_r;
  logic             wrap_d;
  logic             hit_r;
  logic             hit_d;

  logic             cfg_err;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] calc_q;
  logic             calc_wrap;
  logic             calc_hit;

  assign cfg_err = bus.lo > bus.hi;

  assign load_clamped = (bus.load_val < bus.lo) ? bus.lo :
                        (bus.load_val > bus.hi) ? bus.hi : bus.load_val;

  counter_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .q        (q_r),
    .step     (bus.step),
    .up       (bus.up),
    .sat      (bus.sat),
    .lo       (bus.lo),
    .hi       (bus.hi),
    .q_nxt    (calc_q),
    .wrap_nxt (calc_wrap),
    .hit_nxt  (calc_hit)
  );

  always_comb begin
    q_d    = q_r;
    wrap_d = 1'b0;
    hit_d  = 1'b0;
    if (bus.clr) begin
      q_d = bus.lo;
    end else if (bus.load) begin
      // With inverted bounds there is no valid range to clamp into.
      q_d = cfg_err ? bus.load_val : load_clamped;
    end else if (!cfg_err && bus.en) begin
      // Bounds moved under q: snap back to the violated bound before counting again.
      if (q_r < bus.lo) begin
        q_d = bus.lo;
      end else if (q_r > bus.hi) begin
        q_d = bus.hi;
      end else begin
        q_d    = calc_q;
        wrap_d = calc_wrap;
        hit_d  = calc_hit;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= RST_VAL;
      wrap_r <= 1'b0;
      hit_r  <= 1'b0;
    end else begin
      q_r    <= q_d;
      wrap_r <= wrap_d;
      hit_r  <= hit_d;
    end
  end

  assign bus.q       = q_r;
  assign bus.wrap    = wrap_r;
  assign bus.hit     = hit_r;
  assign bus.at_lo   = (q_r == bus.lo);
  assign bus.at_hi   = (q_r == bus.hi);
  assign bus.cfg_err = cfg_err;

endmodule : updown_counter_bounded

// File: tb/tb_updown_counter_bounded.sv
// Directed bench for updown_counter_bounded (WIDTH=8, STEP_W=4, RST_VAL=0)
// with hand-computed expected values.
module tb_updown_counter_bounded;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  updown_counter_bounded_if #(.WIDTH(8), .STEP_W(4)) bus ();

  updown_counter_bounded #(
    .WIDTH   (8),
    .STEP_W  (4),
    .RST_VAL (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    tick();
    bus.load     = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.step     = 4'd1;
    bus.sat      = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 8'h00;
    bus.lo       = 8'h00;
    bus.hi       = 8'hFF;
    #2;
    check("reset_q", bus.q, 8'h00);
    check("reset_wrap", bus.wrap, 1'b0);
    check("reset_hit", bus.hit, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-count, then legacy-style counting.
    do_load(8'h37);
    check("load_37", bus.q, 8'h37);
    #3 rst = 1'b1;
    #1;
    check("async_rst_q", bus.q, 8'h00);
    check("async_rst_wrap", bus.wrap, 1'b0);
    check("async_rst_hit", bus.hit, 1'b0);
    #1 rst = 1'b0;
    bus.en = 1'b1; bus.up = 1'b1; bus.step = 4'd1;
    tick(); tick(); tick();
    check("count_3", bus.q, 8'h03);

    // Wrap upward in [0x10,0x20] with step 3.
    bus.en = 1'b0; bus.lo = 8'h10; bus.hi = 8'h20;
    do_load(8'h1F);
    check("load_1f", bus.q, 8'h1F);
    bus.en = 1'b1; bus.up = 1'b1; bus.step = 4'd3; bus.sat = 1'b0;
    tick();
    check("wrap_up_q", bus.q, 8'h10);
    check("wrap_up_flag", bus.wrap, 1'b1);
    check("wrap_up_hit", bus.hit, 1'b0);
    check("wrap_up_at_lo", bus.at_lo, 1'b1);
    tick();
    check("after_wrap_q", bus.q, 8'h13);
    check("after_wrap_flag", bus.wrap, 1'b0);

    // Saturating down count clipped at lo, twice.
    bus.en = 1'b0;
    do_load(8'h12);
    bus.en = 1'b1; bus.sat = 1'b1; bus.up = 1'b0; bus.step = 4'd5;
    tick();
    check("sat_dn_q", bus.q, 8'h10);
    check("sat_dn_hit", bus.hit, 1'b1);
    check("sat_dn_wrap", bus.wrap, 1'b0);
    tick();
    check("sat_dn2_q", bus.q, 8'h10);
    check("sat_dn2_hit", bus.hit, 1'b1);
    check("sat_dn2_at_lo", bus.at_lo, 1'b1);

    // Saturating up count starting at hi, then step 0 holds with no flag.
    bus.en = 1'b0;
    do_load(8'h20);
    bus.en = 1'b1; bus.up = 1'b1; bus.step = 4'd2;
    tick();
    check("sat_up_q", bus.q, 8'h20);
    check("sat_up_hit", bus.hit, 1'b1);
    check("sat_up_at_hi", bus.at_hi, 1'b1);
    bus.step = 4'd0;
    tick();
    check("step0_q", bus.q, 8'h20);
    check("step0_hit", bus.hit, 1'b0);

    // Load clamping and clr-over-load priority.
    bus.en = 1'b0; bus.sat = 1'b0;
    do_load(8'h05);
    check("load_clamp_lo", bus.q, 8'h10);
    do_load(8'h7A);
    check("load_clamp_hi", bus.q, 8'h20);
    do_load(8'h1A);
    check("load_in_range", bus.q, 8'h1A);
    bus.clr = 1'b1;
    do_load(8'h1C);
    bus.clr = 1'b0;
    check("clr_over_load", bus.q, 8'h10);

    // Out-of-range q after hi shrinks: held while disabled, then snapped to hi.
    do_load(8'h18);
    bus.hi = 8'h14;
    tick();
    check("oor_idle_q", bus.q, 8'h18);
    check("oor_idle_at_hi", bus.at_hi, 1'b0);
    bus.en = 1'b1; bus.up = 1'b1; bus.step = 4'd1;
    tick();
    check("oor_snap_q", bus.q, 8'h14);
    check("oor_snap_wrap", bus.wrap, 1'b0);
    check("oor_snap_hit", bus.hit, 1'b0);
    check("oor_snap_at_hi", bus.at_hi, 1'b1);

    // Inverted bounds: counting frozen, load unclamped, clr still goes to lo.
    bus.lo = 8'h30; bus.hi = 8'h20;
    #1;
    check("cfg_err", bus.cfg_err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cfg_hold_q", bus.q, 8'h14);
      check("cfg_hold_wrap", bus.wrap, 1'b0);
      check("cfg_hold_hit", bus.hit, 1'b0);
    end
    do_load(8'h50);
    check("cfg_load_unclamped", bus.q, 8'h50);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("cfg_clr", bus.q, 8'h30);

    // lo == hi: pinned value, wrap every enabled count in either direction.
    bus.en = 1'b0; bus.lo = 8'h40; bus.hi = 8'h40;
    #1;
    check("cfg_ok", bus.cfg_err, 1'b0);
    do_load(8'h00);
    check("pin_load", bus.q, 8'h40);
    bus.en = 1'b1; bus.up = 1'b1; bus.step = 4'd1; bus.sat = 1'b0;
    tick();
    check("pin_up_q", bus.q, 8'h40);
    check("pin_up_wrap", bus.wrap, 1'b1);
    bus.up = 1'b0;
    tick();
    check("pin_dn_q", bus.q, 8'h40);
    check("pin_dn_wrap", bus.wrap, 1'b1);

    // Full-range legacy behaviour across FF <-> 00.
    bus.en = 1'b0; bus.lo = 8'h00; bus.hi = 8'hFF;
    do_load(8'hFF);
    bus.en = 1'b1; bus.up = 1'b1; bus.step = 4'd1;
    tick();
    check("full_up_q", bus.q, 8'h00);
    check("full_up_wrap", bus.wrap, 1'b1);
    bus.up = 1'b0;
    tick();
    check("full_dn_q", bus.q, 8'hFF);
    check("full_dn_wrap", bus.wrap, 1'b1);
    tick();
    check("full_dn2_q", bus.q, 8'hFE);
    check("full_dn2_wrap", bus.wrap, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_updown_counter_bounded

// File: doc/updown_counter_bounded.md
Name: updown_counter_bounded

Overview:
Parametrised up/down counter with programmable lower/upper bounds, step size, synchronous load/clear and wrap-or-saturate mode. Generalises the team's fixed 8-bit 00..FF up/down counter for timer, address-sweep and PWM-period uses. Outputs a registered count plus boundary and event flags for downstream control logic.

Parameters:
WIDTH, 8, counter/bound/load width in bits (>=2)
STEP_W, 4, width of step input
RST_VAL, 0, value of q after reset (WIDTH bits; integrator keeps within bounds)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  count enable
up  in  1  direction: 1 = up, 0 = down
step  in  STEP_W  increment/decrement amount; 0 = hold
sat  in  1  1 = saturate at bound, 0 = wrap to opposite bound
clr  in  1  synchronous clear to lo
load  in  1  synchronous load
load_val  in  WIDTH  value for load
lo  in  WIDTH  lower bound (inclusive, unsigned)
hi  in  WIDTH  upper bound (inclusive, unsigned)
q  out  WIDTH  registered count
at_lo  out  1  q == lo (combinational from q)
at_hi  out  1  q == hi (combinational from q)
wrap  out  1  registered; 1 for the cycle after a wrap occurred
hit  out  1  registered; 1 for the cycle after a saturating count was clipped
cfg_err  out  1  combinational; lo > hi

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On rst: q = RST_VAL, wrap = 0, hit = 0; takes effect immediately, independent of clk.
- Per rising edge, priority: clr > load > cfg_err hold > en count > hold.
- clr: q <= lo. wrap/hit <= 0.
- load: q <= load_val clamped to [lo,hi] (below lo -> lo, above hi -> hi). wrap/hit <= 0.
- cfg_err (lo > hi): q holds, wrap/hit <= 0; clr and load still act (clr -> lo; load unclamped).
- en=1, step=0: q holds, flags 0.
- Up count: sum = q + step computed in WIDTH+1 bits (no native overflow).
  - sum <= hi: q <= sum.
  - sum > hi, sat=1: q <= hi, hit <= 1 (hit also 1 when q already == hi and step>0).
  - sum > hi, sat=0: q <= lo, wrap <= 1 (excess discarded).
- Down count: diff = q - step in WIDTH+1 bits signed-safe (borrow detected).
  - diff >= lo and no borrow: q <= diff.
  - otherwise sat=1: q <= lo, hit <= 1; sat=0: q <= hi, wrap <= 1.
- q outside [lo,hi] (bounds changed at runtime): next enabled count first forces q to nearer violated bound (q<lo -> lo, q>hi -> hi), no flag; no action while en=0.
- wrap and hit are single-cycle pulses; never both 1.
- lo == hi: q pinned to lo on any count; up/down with sat=0 raises wrap each enabled cycle.
- Latency: one clock from inputs to q; at_lo/at_hi track q combinationally.
- Full-range default (lo=0, hi=2^WIDTH-1, step=1, sat=0) reproduces the legacy 00..FF wrapping up/down counter.

Decomposition:
- Shared package counter_pkg: mode constants (MODE_WRAP=0, MODE_SAT=1), direction constants (DIR_DOWN=0, DIR_UP=1).
- One combinational sub-module, counter_next_calc: takes q, step, up, sat, lo, hi; returns next value, wrap_nxt, hit_nxt. Top holds registers, priority mux, clamp and flags.

Test Plan:
- rst=1 mid-count with q=0x37, no clk edge -> q=0x00 immediately, wrap=hit=0; release, lo=0,hi=0xFF,up=1,step=1, 3 edges -> q=0x03.
- lo=0x10, hi=0x20, sat=0, up=1, step=3, q=0x1F -> next q=0x10, wrap=1 one cycle; then q=0x13, wrap=0.
- Same bounds, sat=1, up=0, step=5, q=0x12 -> q=0x10, hit=1; next edge q=0x10, hit=1 again; at_lo=1.
- load=1, load_val=0x05, lo=0x10, hi=0x20 -> q=0x10; same cycle clr=1 -> q=0x10 via clr, load ignored.
- lo=0x30, hi=0x20, en=1 -> cfg_err=1, q holds across 4 edges; flags stay 0.
- Full range, up=1, step=1, q=0xFF -> q=0x00, wrap=1; up=0, q=0x00 -> q=0xFF, wrap=1.
